free_list_ctrl: RTL

- Allocator and sequencer for the physical-register free list that feeds the rename map table.
- At dispatch, pops the next free physical register (T) and hands it to the map table.
- At retire, recycles the committed instruction's T_old.
- On branch rollback, restores the allocation pointer from a per-ROB-entry checkpoint so the free list stays consistent with the restored map table.

---
 rtl/free_list_ctrl.sv | 81 ++++++++
 1 files changed

// File: rtl/free_list_ctrl.sv
// Physical-register free list for rename: pops T at dispatch, recycles T_old at
// retire, and restores the allocation pointer from per-ROB checkpoints on rollback.
module free_list_ctrl #(
   parameter int NUM_PR  = 64,
   parameter int NUM_ROB = 32,
   parameter int NUM_AR  = 32
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                en,
   input  logic                                dispatch_en,
   input  logic [4:0]                          dest_idx,
   input  logic [$clog2(NUM_ROB)-1:0]          ROB_idx,
   input  logic                                retire_en,
   input  logic [$clog2(NUM_PR)-1:0]           retire_Told_idx,
   input  logic                                rollback_en,
   input  logic [$clog2(NUM_ROB)-1:0]          ROB_rollback_idx,
   output logic [$clog2(NUM_PR)-1:0]           free_T_idx,
   output logic                                free_valid,
   output logic [$clog2(NUM_PR-NUM_AR):0]      free_count
);

   // DEPTH must be a power of two so the pointers wrap by plain modular arithmetic.
   localparam int DEPTH = NUM_PR - NUM_AR;
   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;
   localparam int PR_W  = $clog2(NUM_PR);
   localparam logic [4:0]       ZERO_AR   = 5'(NUM_AR - 1);
   localparam logic [PR_W-1:0]  ZERO_PR   = PR_W'(NUM_AR - 1);
   localparam logic [PTR_W-1:0] FULL_CNT  = PTR_W'(DEPTH);

   logic [PR_W-1:0]  fl_q   [DEPTH];
   logic [PTR_W-1:0] ckpt_q [NUM_ROB];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [PTR_W-1:0] headAfterPop;
   logic [PTR_W-1:0] countNow;
   logic             popFire;
   logic             pushFire;

   assign countNow   = tail_q - head_q;
   assign free_count = countNow;
   assign free_valid = (countNow != '0);
   assign free_T_idx = (dispatch_en && dest_idx == ZERO_AR) ? ZERO_PR : fl_q[head_q[IDX_W-1:0]];

   // Rollback overrides the pop; the retire push is independent of both.
   always_comb begin
      popFire      = en && dispatch_en && !rollback_en && free_valid && (dest_idx != ZERO_AR);
      pushFire     = en && retire_en && (retire_Told_idx != ZERO_PR) && (countNow != FULL_CNT);
      headAfterPop = head_q + {{(PTR_W-1){1'b0}}, popFire};
      head_d       = rollback_en ? ckpt_q[ROB_rollback_idx] : headAfterPop;
      tail_d       = tail_q + {{(PTR_W-1){1'b0}}, pushFire};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head_q <= '0;
         tail_q <= FULL_CNT;
         for (int i = 0; i < DEPTH; i++) begin
            fl_q[i] <= PR_W'(NUM_AR + i);
         end
         for (int r = 0; r < NUM_ROB; r++) begin
            ckpt_q[r] <= '0;
         end
      end else if (en) begin
         head_q <= head_d;
         tail_q <= tail_d;
         if (pushFire) begin
            fl_q[tail_q[IDX_W-1:0]] <= retire_Told_idx;
         end
         if (dispatch_en && !rollback_en) begin
            ckpt_q[ROB_idx] <= headAfterPop;
         end
      end
   end

   // Recycling into an already-full list means upstream lost track of a register.
   pushWhenFull: assert property (@(posedge clock) disable iff (reset)
      !(en && retire_en && (retire_Told_idx != ZERO_PR) && (countNow == FULL_CNT)));

endmodule
